serial_subtractor_ctrl: RTL and testbench

//  Bit-serial WIDTH-bit subtractor: diff = a - b, one bit per clock, LSB first.
//  The per-bit datapath is a full subtractor built from two half-subtractor cells.
//  A small FSM sequences it under a start/busy/done handshake.

---
 rtl/serial_subtractor_ctrl.sv | 67 ++++++
 tb/tb_serial_subtractor_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: bit-serial a-b, LSB first, full subtractor from two half subtractors
// under a start/busy/done handshake.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_res, w_res;
  logic [CW-1:0] r_cnt;
  logic r_brw, w_d1, w_b1, w_d, w_b2, w_brw, w_last;
  assign w_d1   = r_a[0] ^ r_b[0];
  assign w_b1   = ~r_a[0] & r_b[0];
  assign w_d    = w_d1 ^ r_brw;
  assign w_b2   = ~w_d1 & r_brw;
  assign w_brw  = w_b1 | w_b2;
  // shift the new bit in at the top; written this way so WIDTH=1 needs no empty slice
  assign w_res  = WIDTH'({w_d, r_res} >> 1);
  assign w_last = r_cnt == CW'(WIDTH - 1);
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE  ? (start ? SHIFT : IDLE) :
             r_state == SHIFT ? (w_last ? DONE : SHIFT) : IDLE;
    busy   = r_state == SHIFT;
    done   = r_state == DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_brw      <= 1'b0;
      r_cnt      <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_a   <= a;
        r_b   <= b;
        r_brw <= 1'b0;
        r_cnt <= '0;
      end else if (r_state == SHIFT) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_brw <= w_brw;
        r_res <= w_res;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          diff       <= w_res;
          borrow_out <= w_brw;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb_serial_subtractor_ctrl: directed checks of 8-bit and 1-bit serial subtractors against
// an arithmetic reference held in a scoreboard queue.
module tb_serial_subtractor_ctrl;
  typedef struct {logic [7:0] d; logic bo;} exp_t;
  logic clk = 0, rst = 1;
  logic start8 = 0, busy8, done8, bo8;
  logic [7:0] a8 = 0, b8 = 0, diff8;
  logic start1 = 0, busy1, done1, bo1;
  logic [0:0] a1 = 0, b1 = 0, diff1;
  exp_t q[$];
  int checks = 0, errors = 0;

  serial_subtractor_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8));
  serial_subtractor_ctrl #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input int w);
    logic [8:0] r;
    exp_t e;
    r = w == 8 ? {1'b0, x} - {1'b0, y} : {8'b0, x[0]} - {8'b0, y[0]};
    e.d  = w == 8 ? r[7:0] : {7'b0, r[0]};
    e.bo = w == 8 ? r[8] : r[1];
    return e;
  endfunction

  task automatic compare(input string tag, input logic [7:0] d, input logic bo);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, "_queue_empty"}, 1, 0);
      return;
    end
    e = q.pop_front();
    chk({tag, "_diff"}, d, e.d);
    chk({tag, "_borrow"}, bo, e.bo);
  endtask

  // done is expected on the (WIDTH+1)th falling edge after the accepting rising edge
  task automatic run8(input string tag, input logic [7:0] ia, input logic [7:0] ib);
    int n = 0;
    @(negedge clk);
    start8 = 1; a8 = ia; b8 = ib;
    q.push_back(model(ia, ib, 8));
    do begin
      @(negedge clk);
      start8 = 0; a8 = ~ia; b8 = ~ib; n++;
      if (n == 1) chk({tag, "_busy"}, busy8, 1);
    end while (!done8 && n < 20);
    chk({tag, "_latency"}, n, 9);
    compare(tag, diff8, bo8);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done8, 0);
  endtask

  task automatic run1(input string tag, input logic ia, input logic ib);
    int n = 0;
    @(negedge clk);
    start1 = 1; a1 = ia; b1 = ib;
    q.push_back(model({7'b0, ia}, {7'b0, ib}, 1));
    do begin
      @(negedge clk);
      start1 = 0; a1 = ~ia; b1 = ~ib; n++;
    end while (!done1 && n < 10);
    chk({tag, "_latency"}, n, 2);
    compare(tag, {7'b0, diff1}, bo1);
  endtask

  initial begin
    int dones, first, last;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_diff", diff8, 0);
    chk("rst_borrow", bo8, 0);
    rst = 0;
    run8("sub_5_3", 8'h05, 8'h03);
    run8("sub_3_5", 8'h03, 8'h05);
    run8("sub_0_1", 8'h00, 8'h01);
    run8("sub_ff_ff", 8'hFF, 8'hFF);
    run8("sub_80_7f", 8'h80, 8'h7F);
    // a second start mid-SHIFT must be ignored, not queued
    @(negedge clk);
    start8 = 1; a8 = 8'h10; b8 = 8'h01;
    q.push_back(model(8'h10, 8'h01, 8));
    dones = 0; first = 0;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (n == 1) start8 = 0;
      if (n == 3) begin start8 = 1; a8 = 8'h00; b8 = 8'hFF; end
      if (n == 4) start8 = 0;
      if (done8) begin
        dones++;
        if (first == 0) begin
          first = n;
          compare("reject", diff8, bo8);
        end
      end
    end
    chk("reject_dones", dones, 1);
    chk("reject_when", first, 9);
    // start held high: accepts at k, k+10, k+20, k+30
    @(negedge clk);
    start8 = 1; a8 = 8'h20; b8 = 8'h01;
    repeat (4) q.push_back(model(8'h20, 8'h01, 8));
    dones = 0; last = 0;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (n == 31) start8 = 0;
      if (done8) begin
        dones++;
        chk("held_gap", n - last, last == 0 ? 9 : 10);
        last = n;
        compare("held", diff8, bo8);
      end
    end
    chk("held_dones", dones, 4);
    // abort three cycles into SHIFT
    @(negedge clk);
    start8 = 1; a8 = 8'h55; b8 = 8'h11;
    repeat (3) begin @(negedge clk); start8 = 0; end
    chk("abort_busy_before", busy8, 1);
    rst = 1;
    #1;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_diff", diff8, 0);
    chk("abort_borrow", bo8, 0);
    @(negedge clk);
    rst = 0;
    dones = 0;
    repeat (12) begin @(negedge clk); if (done8) dones++; end
    chk("abort_no_done", dones, 0);
    run8("sub_9_4", 8'h09, 8'h04);
    run1("w1_00", 1'b0, 1'b0);
    run1("w1_01", 1'b0, 1'b1);
    run1("w1_10", 1'b1, 1'b0);
    run1("w1_11", 1'b1, 1'b1);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
